// File: rtl/fetch_decode_bus_pkg.sv
// Shared types and defaults for the fetch-to-decode bus arbiter slice.
// Contents:
//   NUM_REQ_DEF / PKT_W_DEF / SRC_W_DEF : default requester count, packet width, ID width
//   fetch_to_decode_bus_packet_t        : one bus packet at the default width
//   slot_state_e                        : slot FSM encoding (SLOT_EMPTY, SLOT_FULL)
package fetch_decode_bus_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int PKT_W_DEF   = 64;
  localparam int SRC_W_DEF   = 2;   // clog2(NUM_REQ_DEF)

  typedef logic [PKT_W_DEF-1:0] fetch_to_decode_bus_packet_t;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/fetch_decode_bus_arbiter_if.sv
// Bus bundle between the fetch requesters, the arbiter and decode.
// Handshake: requester i offers req_pkt[i] while req_valid[i]=1; the packet is
// taken at the clock edge of any cycle in which req_grant[i]=1. Decode sees a
// packet while dec_valid=1 and consumes it at the edge of a cycle where
// dec_ready=1 (dec_ready is ignored while dec_valid=0).
// Modports:
//   master : arbiter side (drives grants, dec_*, busy_cycles, debug state)
//   slave  : environment side (drives requests, dec_ready, flush)
interface fetch_decode_bus_arbiter_if
  import fetch_decode_bus_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int PKT_W   = PKT_W_DEF,
  parameter int SRC_W   = SRC_W_DEF
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*PKT_W-1:0] req_pkt;
  logic [NUM_REQ-1:0]       req_grant;
  logic                     dec_valid;
  logic [PKT_W-1:0]         dec_pkt;
  logic [SRC_W-1:0]         dec_src;
  logic                     dec_ready;
  logic                     flush;
  logic [15:0]              busy_cycles;
  logic [0:0]               dbg_state;   // slot FSM state
  logic [SRC_W-1:0]         dbg_rr_ptr;  // round-robin pointer

  modport master (
    input  req_valid, req_pkt, dec_ready, flush,
    output req_grant, dec_valid, dec_pkt, dec_src, busy_cycles, dbg_state, dbg_rr_ptr
  );

  modport slave (
    output req_valid, req_pkt, dec_ready, flush,
    input  req_grant, dec_valid, dec_pkt, dec_src, busy_cycles, dbg_state, dbg_rr_ptr
  );
endinterface

// File: rtl/fetch_decode_bus_arbiter_rr_arbiter.sv
// Round-robin priority picker.
// Ports:
//   req     in  NUM_REQ  request vector (already masked by the caller)
//   rr_ptr  in  SRC_W    index with highest priority this cycle
//   gnt     out NUM_REQ  one-hot grant, zero when no request
//   gnt_idx out SRC_W    encoded index of the granted bit (0 when none)
//   gnt_any out 1        some bit of gnt is set
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SRC_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  // Walk the requesters starting at rr_ptr and stop at the first set bit.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_any && req[j]) begin
        gnt_any = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = SRC_W'(j);
      end
    end
  end

endmodule

// File: rtl/fetch_decode_bus_arbiter.sv
// Single-entry fetch-to-decode bus slot shared by NUM_REQ fetch requesters
// with round-robin arbitration. The slot only accepts when it is free and
// only empties when decode takes it, so neither rule relies on the users.
// Ports:
//   clk, rst_n : core clock, synchronous active-low reset
//   bus        : fetch_decode_bus_arbiter_if.master (requests, grants, dec_*,
//                flush, busy_cycles, debug state / rr pointer)
// Build option:
//   FDB_SAME_CYCLE_REFILL_EN : when defined, a FULL slot that decode is
//   consuming may be refilled at the same edge (one packet per cycle).
module fetch_decode_bus_arbiter
  import fetch_decode_bus_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int PKT_W   = PKT_W_DEF,
  parameter int SRC_W   = SRC_W_DEF
) (
  input logic                      clk,
  input logic                      rst_n,
  fetch_decode_bus_arbiter_if.master bus
);

  localparam logic [0:0]       ST_EMPTY = SLOT_EMPTY;
  localparam logic [0:0]       ST_FULL  = SLOT_FULL;
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);

  logic [0:0]         state;
  logic [PKT_W-1:0]   slot_pkt;
  logic [SRC_W-1:0]   slot_src;
  logic [SRC_W-1:0]   rr_ptr;
  logic [15:0]        busy_cnt;

  logic               can_accept;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] gnt;
  logic [SRC_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [PKT_W-1:0]   gnt_pkt;

`ifdef FDB_SAME_CYCLE_REFILL_EN
  assign can_accept = (state == ST_EMPTY) || bus.dec_ready;
`else
  assign can_accept = (state == ST_EMPTY);
`endif

  // Masking the requests (not the grant) keeps the grant free of req_pkt
  // and makes flush/reset suppression a single point.
  assign arb_req = (can_accept && !bus.flush && rst_n) ? bus.req_valid : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_rr_arbiter (
    .req     (arb_req),
    .rr_ptr  (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // One-hot mux of the winning packet.
  always_comb begin
    gnt_pkt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_pkt = bus.req_pkt[i*PKT_W +: PKT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      slot_pkt <= '0;
      slot_src <= '0;
      rr_ptr   <= '0;
      busy_cnt <= '0;
    end else begin
      if ((state == ST_FULL) && !bus.dec_ready && !bus.flush && (busy_cnt != 16'hFFFF))
        busy_cnt <= busy_cnt + 16'd1;

      if (bus.flush) begin
        state <= ST_EMPTY;
      end else if (gnt_any) begin
        // Covers both a fill into EMPTY and a pop+refill into FULL.
        state    <= ST_FULL;
        slot_pkt <= gnt_pkt;
        slot_src <= gnt_idx;
        rr_ptr   <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + SRC_W'(1);
      end else if ((state == ST_FULL) && bus.dec_ready) begin
        state <= ST_EMPTY;
      end
    end
  end

  assign bus.req_grant   = gnt;
  assign bus.dec_valid   = (state == ST_FULL);
  assign bus.dec_pkt     = slot_pkt;
  assign bus.dec_src     = slot_src;
  assign bus.busy_cycles = busy_cnt;
  assign bus.dbg_state   = state;
  assign bus.dbg_rr_ptr  = rr_ptr;

endmodule

// File: tb/tb_fetch_decode_bus_arbiter.sv
// Bench for fetch_decode_bus_arbiter: directed scenarios followed by random
// traffic, all checked against a behavioural slot/round-robin model and an
// expected-packet queue. Honours FDB_SAME_CYCLE_REFILL_EN in the model.
module tb_fetch_decode_bus_arbiter;

  localparam int N = 4;
  localparam int W = 64;
  localparam int S = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_decode_bus_arbiter_if #(.NUM_REQ(N), .PKT_W(W), .SRC_W(S)) bus ();

  fetch_decode_bus_arbiter #(.NUM_REQ(N), .PKT_W(W), .SRC_W(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // ---------------- scoreboard / model state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] pkts[N];
  int          obs_g[$];   // grant indices observed on the DUT

  bit          m_full;
  logic [W-1:0] m_pkt;
  int          m_src;
  int          m_ptr;
  int          m_busy;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Winner by the rules: none under reset/flush or when the slot cannot
  // accept, else first valid requester scanning upward from the pointer.
  function automatic int model_grant(logic [N-1:0] v, bit rdy, bit fl, bit rst);
    bit can;
    if (!rst || fl) return -1;
`ifdef FDB_SAME_CYCLE_REFILL_EN
    can = !m_full || rdy;
`else
    can = !m_full;
`endif
    if (!can) return -1;
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // ---------------- driver ----------------
  task automatic run_cycle(input logic [N-1:0] v, input bit rdy, input bit fl, input bit rst);
    int g;
    logic [N-1:0] exp_gnt;
    logic [W-1:0] want;
    bus.req_valid = v;
    bus.dec_ready = rdy;
    bus.flush     = fl;
    rst_n         = rst;
    bus.req_pkt   = {pkts[3], pkts[2], pkts[1], pkts[0]};
    #1;
    g = model_grant(v, rdy, fl, rst);
    exp_gnt = (g >= 0) ? 4'(1 << g) : 4'b0;
    check_eq("req_grant",   64'(bus.req_grant),   64'(exp_gnt));
    check_eq("dec_valid",   64'(bus.dec_valid),   64'(m_full));
    check_eq("dec_pkt",     bus.dec_pkt,          m_pkt);
    check_eq("dec_src",     64'(bus.dec_src),     64'(m_src));
    check_eq("busy_cycles", 64'(bus.busy_cycles), 64'(m_busy));
    check_eq("rr_ptr",      64'(bus.dbg_rr_ptr),  64'(m_ptr));
    for (int i = 0; i < N; i++)
      if (bus.req_grant[i]) obs_g.push_back(i);
    if (rst && !fl && m_full && rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_pkt: pop with empty expected queue (t=%0t)", $time);
      end else begin
        want = exp_q.pop_front();
        check_eq("sb_pkt", bus.dec_pkt, want);
      end
    end
    @(posedge clk);
    if (!rst) begin
      m_full = 1'b0; m_pkt = '0; m_src = 0; m_ptr = 0; m_busy = 0;
      exp_q.delete();
    end else begin
      if (m_full && !rdy && !fl && m_busy < 65535) m_busy++;
      if (fl) begin
        m_full = 1'b0;
        exp_q.delete();
      end else if (g >= 0) begin
        m_full = 1'b1;
        m_pkt  = pkts[g];
        m_src  = g;
        m_ptr  = (g + 1) % N;
        exp_q.push_back(pkts[g]);
      end else if (m_full && rdy) begin
        m_full = 1'b0;
      end
    end
    #1;
  endtask

  task automatic check_grant_seq(input string tag, input int exp_seq[5], input int cnt);
    check_eq({tag, "_count_ok"}, 64'(obs_g.size() >= cnt), 64'(1));
    for (int k = 0; k < cnt; k++)
      if (k < obs_g.size()) check_eq(tag, 64'(obs_g[k]), 64'(exp_seq[k]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seq1[5] = '{1, 3, 1, 3, 1};
    int seq2[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) pkts[i] = 64'hA0 + 64'(i);
    bus.req_valid = '0;
    bus.req_pkt   = '0;
    bus.dec_ready = 1'b0;
    bus.flush     = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_full = 1'b0; m_pkt = '0; m_src = 0; m_ptr = 0; m_busy = 0;

    // Reset state, with requests pending during reset.
    run_cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    check_eq("rst_dec_valid", 64'(bus.dec_valid), 64'(0));
    check_eq("rst_dec_pkt",   bus.dec_pkt,        64'(0));
    check_eq("rst_busy",      64'(bus.busy_cycles), 64'(0));

    // Alternating requesters 1 and 3.
    obs_g.delete();
    repeat (8) run_cycle(4'b1010, 1'b1, 1'b0, 1'b1);
    check_grant_seq("s1_grant", seq1, 4);
    check_eq("s1_busy", 64'(bus.busy_cycles), 64'(0));

    // All four requesting from rr_ptr=0; pointer must wrap 3 -> 0.
    run_cycle(4'b0000, 1'b0, 1'b0, 1'b0);
    obs_g.delete();
    repeat (10) run_cycle(4'b1111, 1'b1, 1'b0, 1'b1);
    check_grant_seq("s2_grant", seq2, 5);

    // Fill from requester 2 then stall decode for 10 cycles.
    run_cycle(4'b0000, 1'b0, 1'b0, 1'b0);
    run_cycle(4'b0100, 1'b0, 1'b0, 1'b1);
    obs_g.delete();
    repeat (10) run_cycle(4'b0001, 1'b0, 1'b0, 1'b1);
    check_eq("s3_no_grant", 64'(obs_g.size()), 64'(0));
    check_eq("s3_busy",     64'(bus.busy_cycles), 64'(10));
    check_eq("s3_pkt",      bus.dec_pkt, pkts[2]);

    // Flush a full slot, then requester 0 is granted.
    obs_g.delete();
    run_cycle(4'b0001, 1'b0, 1'b1, 1'b1);
    check_eq("s4_flush_grant", 64'(obs_g.size()), 64'(0));
    check_eq("s4_valid",       64'(bus.dec_valid), 64'(0));
    run_cycle(4'b0001, 1'b0, 1'b0, 1'b1);
    check_eq("s4_regrant", 64'(obs_g.size() == 1 && obs_g[0] == 0), 64'(1));

    // Reset while full with requests pending.
    run_cycle(4'b1111, 1'b0, 1'b0, 1'b0);
    check_eq("s5_valid", 64'(bus.dec_valid),   64'(0));
    check_eq("s5_busy",  64'(bus.busy_cycles), 64'(0));
    obs_g.delete();
    run_cycle(4'b1111, 1'b1, 1'b0, 1'b1);
    check_eq("s5_first_grant", 64'(obs_g.size() == 1 && obs_g[0] == 0), 64'(1));

    // Random traffic.
    repeat (400) begin
      for (int i = 0; i < N; i++) pkts[i] = {$urandom, $urandom};
      run_cycle(4'($urandom_range(0, 15)),
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0,
                $urandom_range(0, 31) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_decode_bus_arbiter.md
Name: fetch_decode_bus_arbiter

Overview:
- Shares the single-entry fetch-to-decode bus between NUM_REQ fetch requesters (per hardware thread / fetch unit) using round-robin arbitration.
- Owns the bus slot: `is_busy` flag, packet, source ID. Enforces the send-only-when-free / recv-only-when-busy rules in hardware rather than by assertion.
- Sits between the fetch stage(s) and the decode stage.

Parameters:
- NUM_REQ, 4, number of fetch requesters (2..8).
- PKT_W, 64, width of a fetch-to-decode packet in bits.
- SRC_W, 2, requester-ID width; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  requester i has a packet to send.
- req_pkt  in  NUM_REQ*PKT_W  packet of requester i, at bits [i*PKT_W +: PKT_W].
- req_grant  out  NUM_REQ  one-hot (or zero). Requester i's packet is accepted this cycle.
- dec_valid  out  1  bus slot busy; equals `is_busy`.
- dec_pkt  out  PKT_W  slot packet.
- dec_src  out  SRC_W  requester ID of the slot packet.
- dec_ready  in  1  decode consumes the slot this cycle (recv).
- flush  in  1  discard the slot contents and suppress grants this cycle.
- busy_cycles  out  16  saturating count of cycles with dec_valid=1 and dec_ready=0.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - slot is EMPTY; dec_valid=0; dec_pkt=0; dec_src=0.
  - rr_ptr=0; busy_cycles=0.
  - req_grant=0 while rst_n=0.
  - Reset mid-transfer drops the slot packet. No grant is issued in the reset cycle.
- Slot FSM has two states, EMPTY and FULL. dec_valid = (state==FULL).
- can_accept:
  - EMPTY: 1.
  - FULL: 0. Exception: see FDB_SAME_CYCLE_REFILL_EN.
- Grant (combinational):
  - If can_accept and !flush and rst_n: grant the first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - At most one grant bit set. Zero grants if no request.
  - req_grant must not depend on req_pkt.
- On a clock edge with grant to index g:
  - slot <= req_pkt[g]; dec_src <= g; state <= FULL.
  - rr_ptr <= (g+1) mod NUM_REQ. Wrap from NUM_REQ-1 to 0.
- On a clock edge with no grant: rr_ptr unchanged.
- Recv: when FULL and dec_ready=1, the slot empties at the edge (state <= EMPTY) unless refilled in the same cycle. dec_ready while EMPTY is ignored.
- Latency: a granted packet is visible on dec_* in the cycle after the grant (1 cycle).
- Throughput without the optional feature: one packet per 2 cycles (grant into EMPTY, then pop).
- flush=1:
  - state <= EMPTY; no grant.
  - rr_ptr unchanged.
  - dec_ready is ignored that cycle.
  - flush has priority over everything except reset.
- dec_pkt / dec_src hold their last value while EMPTY. They are not cleared, except by reset.
- busy_cycles: +1 per cycle with FULL && !dec_ready && !flush. Saturates at 16'hFFFF; no wrap.
- A requester deasserting req_valid without a grant is legal. Its packet is simply not taken.

Optional Feature:
- Macro: FDB_SAME_CYCLE_REFILL_EN.
- Defined: can_accept = EMPTY || dec_ready. When FULL with dec_ready=1 and a winning request, the slot is popped and refilled at the same edge; state stays FULL. This gives one packet per cycle.
- Undefined: can_accept = EMPTY only. A pop leaves the slot EMPTY for one cycle.
- flush still blocks grants in both builds.

Decomposition:
- Package `fetch_decode_bus_pkg` holds:
  - the FetchToDecodeBusPacket typedef (PKT_W bits);
  - the slot state enum {SLOT_EMPTY, SLOT_FULL};
  - the NUM_REQ / SRC_W defaults.
- One sub-module, `rr_arbiter`: NUM_REQ-wide round-robin priority picker. Inputs are a request vector and rr_ptr; outputs are a one-hot grant and the encoded index.
- The slot register, FSM and counter live in the top.

Test Plan:
- After reset, req_valid=4'b1010 held, dec_ready=1 every cycle:
  - grants go to 1, then 3, then 1, alternating;
  - dec_src is 1 then 3 one cycle after each grant;
  - busy_cycles=0.
- All four requesting with distinct packets 'hA0..'hA3, dec_ready=1, feature off:
  - grants 0,1,2,3,0 on alternating cycles;
  - rr_ptr wraps 3 -> 0.
- Same stimulus with FDB_SAME_CYCLE_REFILL_EN defined:
  - grants 0,1,2,3 on four consecutive cycles;
  - dec_pkt 'hA0..'hA3 on consecutive cycles; dec_valid stays 1.
- Fill the slot from requester 2, hold dec_ready=0 for 10 cycles with requester 0 valid:
  - no grant for those 10 cycles;
  - busy_cycles=10;
  - dec_pkt stable.
- Slot FULL, assert flush with req_valid=4'b0001:
  - next cycle dec_valid=0 and req_grant=0 in the flush cycle;
  - grant to requester 0 in the following cycle.
- Assert rst_n=0 while FULL with requests pending:
  - next cycle dec_valid=0 and busy_cycles=0;
  - first grant after release goes to requester 0 (rr_ptr=0).
